mont_mul_pipe: RTL and testbench

Parametrised, pipelined Montgomery modular multiplier for the NTT datapath. Each beat computes r = a·b·R⁻¹ mod Q, or the to-Montgomery conversion r = a·R mod Q, on LANES independent coefficient lanes. It uses a valid/ready handshake with full backpressure and a pass-through tag. Defaults target Kyber (Q=3329, R=2^16); other moduli are set by parameters only.

---
 rtl/mont_mul_pipe.sv | 147 ++++++++++++++
 tb/tb_mont_mul_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_pipe.sv
// mont_mul_pipe: three-stage pipelined Montgomery multiplier, LANES lanes wide.
//   mode 0 : r = a * b * R^-1 mod Q
//   mode 1 : r = a * R mod Q   (computed as mont_mul(a, R^2 mod Q); b ignored)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake; in_mode, in_tag, in_a, in_b ride with it
//   out_valid / out_ready    output handshake; out_tag, out_r ride with it
//   busy                     any pipeline stage holds a beat
// Handshake: a beat moves across an interface on a clock edge where valid && ready
// are both high. A producer holding valid keeps its payload stable until ready;
// out_r/out_tag never change while out_valid && !out_ready. in_ready depends
// combinationally on out_ready through the per-stage load chain.
module mont_mul_pipe #(
  parameter int Q        = 3329,
  parameter int COEFF_W  = 12,
  parameter int R_BITS   = 16,
  parameter int QNEG     = 3327,
  parameter int R2_MOD_Q = 1353,
  parameter int LANES    = 1,
  parameter int TAG_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [LANES*COEFF_W-1:0] in_a,
  input  logic [LANES*COEFF_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [LANES*COEFF_W-1:0] out_r,
  output logic                     busy
);

  localparam int PW = 2 * COEFF_W;           // product a*b'
  localparam int SW = R_BITS + COEFF_W + 1;  // s = p + m*Q, always < 2*Q*R
  localparam int TW = COEFF_W + 1;           // t = s >> R_BITS, always < 2*Q

  // Parameter sanity, checked at elaboration.
  localparam longint unsigned MAX_OP = (64'd1 << COEFF_W) - 64'd1;
  localparam longint unsigned Q_L    = 64'(Q);
  localparam longint unsigned R_L    = 64'd1 << R_BITS;

  if (Q % 2 == 0) begin : g_err_q_even
    $error("mont_mul_pipe: Q must be odd");
  end
  if ((64'd1 << COEFF_W) <= Q_L) begin : g_err_coeff_w
    $error("mont_mul_pipe: 2^COEFF_W must exceed Q");
  end
  if (MAX_OP * MAX_OP >= Q_L * R_L) begin : g_err_range
    $error("mont_mul_pipe: (2^COEFF_W-1)^2 must be below Q*R");
  end
  if ((Q_L * 64'(QNEG) + 64'd1) % R_L != 64'd0) begin : g_err_qneg
    $error("mont_mul_pipe: QNEG is not -Q^-1 mod R");
  end

  localparam logic [COEFF_W-1:0] R2_C   = COEFF_W'(R2_MOD_Q);
  localparam logic [R_BITS-1:0]  QNEG_C = R_BITS'(QNEG);
  localparam logic [SW-1:0]      Q_S    = SW'(Q);
  localparam logic [TW-1:0]      Q_T    = TW'(Q);

  // Stage registers
  logic                     v1_q, v2_q, v3_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q, tag3_q;
  logic [LANES*PW-1:0]      p1_q;
  logic [LANES*SW-1:0]      s2_q;
  logic [LANES*COEFF_W-1:0] r3_q;

  // Next-state datapath values
  logic [LANES*PW-1:0]      p_d;
  logic [LANES*SW-1:0]      s_d;
  logic [LANES*COEFF_W-1:0] r_d;

  // ldK: stage K register may capture new content this cycle, either because it
  // is empty (bubble collapse) or because its current beat moves on.
  logic ld1, ld2, ld3;

  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [COEFF_W-1:0] a_l, b_l;
    logic [SW-1:0]      p_s;
    logic [R_BITS-1:0]  m_l;
    logic [TW-1:0]      t_l;

    // Stage 1: mode 1 multiplies by R^2 mod Q so the reduction leaves a*R.
    assign a_l = in_a[i*COEFF_W +: COEFF_W];
    assign b_l = in_mode ? R2_C : in_b[i*COEFF_W +: COEFF_W];
    assign p_d[i*PW +: PW] = PW'(a_l) * PW'(b_l);

    // Stage 2: m makes p + m*Q divisible by R; multiply truncates to R_BITS.
    assign p_s = SW'(p1_q[i*PW +: PW]);
    assign m_l = p_s[R_BITS-1:0] * QNEG_C;
    assign s_d[i*SW +: SW] = p_s + SW'(m_l) * Q_S;

    // Stage 3: low R_BITS of s are zero; one conditional subtract lands in [0,Q).
    assign t_l = TW'(s2_q[i*SW +: SW] >> R_BITS);
    assign r_d[i*COEFF_W +: COEFF_W] = (t_l >= Q_T) ? COEFF_W'(t_l - Q_T) : COEFF_W'(t_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      p1_q   <= '0;
      s2_q   <= '0;
      r3_q   <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          tag1_q <= in_tag;
          p1_q   <= p_d;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          tag2_q <= tag1_q;
          s2_q   <= s_d;
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          tag3_q <= tag2_q;
          r3_q   <= r_d;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_tag   = tag3_q;
  assign out_r     = r3_q;
  assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Bench for mont_mul_pipe with Kyber parameters and four lanes.
module tb_mont_mul_pipe;

  localparam int     Q      = 3329;
  localparam int     CW     = 12;
  localparam int     LANES  = 4;
  localparam int     TAG_W  = 8;
  localparam int     DW     = LANES * CW;
  localparam longint R      = 65536;
  localparam longint RINV   = 169;   // 65536 * 169 = 1 mod 3329
  localparam int     N_BEAT = 1000;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_mode, out_ready;
  logic [TAG_W-1:0] in_tag;
  logic [DW-1:0]    in_a, in_b;
  logic             in_ready, out_valid, busy;
  logic [TAG_W-1:0] out_tag;
  logic [DW-1:0]    out_r;

  always #5 clk = ~clk;

  mont_mul_pipe #(
    .Q(Q), .COEFF_W(CW), .R_BITS(16), .QNEG(3327), .R2_MOD_Q(1353),
    .LANES(LANES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_r(out_r), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int                     errors = 0;
  int                     checks = 0;
  logic [TAG_W+DW-1:0]    exp_q[$];
  bit                     in_fire, out_fire;
  bit                     stall_prev;
  logic [DW-1:0]          prev_r;
  logic [TAG_W-1:0]       prev_tag;
  bit                     obs_valid;
  logic [DW-1:0]          obs_r;
  int                     rx_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on each lane.
  function automatic logic [DW-1:0] model_beat(input logic mode, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [DW-1:0] res;
    longint av, bv, rv;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      av = longint'(a[i*CW +: CW]);
      bv = longint'(b[i*CW +: CW]);
      if (mode) rv = (av * R) % Q;
      else      rv = (((av * bv) % Q) * RINV) % Q;
      res[i*CW +: CW] = CW'(rv);
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return CW'(Q - 1);
      2:       return '1;
      3:       return CW'(Q);
      default: return CW'($urandom_range(0, 4095));
    endcase
  endfunction

  // One clock: sample handshakes at negedge, update scoreboard, then move
  // to just after the next posedge where the caller drives new inputs.
  task automatic cycle();
    @(negedge clk);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    obs_valid = out_valid;
    obs_r     = out_r;
    if (stall_prev) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_r", 64'(out_r), 64'(prev_r));
      check_eq("hold_tag", 64'(out_tag), 64'(prev_tag));
    end
    if (out_fire) begin
      rx_count++;
      check_eq("beat_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [TAG_W+DW-1:0] e;
        e = exp_q.pop_front();
        check_eq("out_tag", 64'(out_tag), 64'(e[TAG_W+DW-1:DW]));
        check_eq("out_r", 64'(out_r), 64'(e[DW-1:0]));
      end
    end
    if (in_fire) exp_q.push_back({in_tag, model_beat(in_mode, in_a, in_b)});
    stall_prev = out_valid && !out_ready;
    prev_r     = out_r;
    prev_tag   = out_tag;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_beat(input logic [TAG_W-1:0] tag);
    in_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < LANES; i++) begin
      in_a[i*CW +: CW] = rnd_op();
      in_b[i*CW +: CW] = rnd_op();
    end
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Lane 0 carries the directed operands; other lanes get random operands.
  task automatic send_single(input string name, input logic mode, input logic [CW-1:0] a0,
                             input logic [CW-1:0] b0, input logic [CW-1:0] exp0);
    int lat;
    bit got;
    load_beat(8'($urandom_range(0, 255)));
    in_mode          = mode;
    in_a[CW-1:0]     = a0;
    in_b[CW-1:0]     = b0;
    out_ready        = 1'b1;
    cycle();
    check_eq({name, "_accept"}, 64'(in_fire), 64'd1);
    in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      if (obs_valid) got = 1'b1;
      else           lat++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'd3);
    check_eq({name, "_r"}, 64'(obs_r[CW-1:0]), 64'(exp0));
  endtask

  // Continuous input with out_ready low; returns number of beats accepted.
  task automatic fill_stalled(input int n_cycles, output int acc);
    acc       = 0;
    out_ready = 1'b0;
    load_beat(8'($urandom_range(0, 255)));
    for (int k = 0; k < n_cycles; k++) begin
      cycle();
      if (in_fire) begin
        acc++;
        load_beat(8'($urandom_range(0, 255)));
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc, nfire, stale, sent, budget;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    in_tag = '0; in_a = '0; in_b = '0;
    stall_prev = 1'b0; rx_count = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_r", 64'(out_r), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    cycle();

    // Directed single beats
    send_single("mm_1_1",       1'b0, 12'd1,    12'd1,    12'd169);
    send_single("mm_2285_1234", 1'b0, 12'd2285, 12'd1234, 12'd1234);
    send_single("mm_3328_3328", 1'b0, 12'd3328, 12'd3328, 12'd169);
    send_single("mm_0_3000",    1'b0, 12'd0,    12'd3000, 12'd0);
    send_single("tm_1",         1'b1, 12'd1,    12'd4095, 12'd2285);
    // 100 * 2285 = 228500 = 68*3329 + 2128
    send_single("tm_100",       1'b1, 12'd100,  12'd4095, 12'd2128);
    // 4095 = 766 mod Q; 766^2 = 852 mod Q; 852 * 169 = 841 mod Q
    send_single("mm_4095_4095", 1'b0, 12'd4095, 12'd4095, 12'd841);

    // Backpressure: exactly three beats fit, then in_ready drops
    fill_stalled(6, acc);
    check_eq("bp_accepted", 64'(acc), 64'd3);
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    check_eq("bp_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_release", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    nfire = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (out_fire) nfire++;
    end
    check_eq("bp_drain_b2b", 64'(nfire), 64'd3);
    check_eq("bp_drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    fill_stalled(4, acc);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    out_ready  = 1'b1;
    cycle();
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (obs_valid) stale++;
    end
    check_eq("midrst_no_stale", 64'(stale), 64'd0);
    send_single("post_rst", 1'b0, 12'd1, 12'd1, 12'd169);

    // Random streaming with 50% out_ready
    sent     = 0;
    rx_count = 0;
    budget   = 20000;
    in_valid = 1'b0;
    while ((sent < N_BEAT || exp_q.size() != 0) && budget > 0) begin
      if (!in_valid && sent < N_BEAT && $urandom_range(0, 3) != 0)
        load_beat(8'(sent));
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (in_fire) begin
        sent++;
        in_valid = 1'b0;
      end
      budget--;
    end
    check_eq("stream_sent", 64'(sent), 64'(N_BEAT));
    check_eq("stream_received", 64'(rx_count), 64'(N_BEAT));
    check_eq("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;
    cycle();
    check_eq("stream_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
